// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM encoding, stall/flush bundles,
// PC width and the drain-counter width helper.
package pipe_ctrl_pkg;

    localparam int XLEN     = 64;
    localparam int PC_WIDTH = XLEN;

    typedef enum logic [2:0] {
        PCTRL_BOOT  = 3'd0,
        PCTRL_RUN   = 3'd1,
        PCTRL_FLUSH = 3'd2,
        PCTRL_DRAIN = 3'd3,
        PCTRL_REDIR = 3'd4
    } pctrl_state_e;

    // Bundle bit order, MSB first: stalls IF/ID/EX/MEM, flushes ID/EX/MEM/WB.
    typedef struct packed {
        logic if_s;
        logic id_s;
        logic ex_s;
        logic mem_s;
    } stall_t;

    typedef struct packed {
        logic id_f;
        logic ex_f;
        logic mem_f;
        logic wb_f;
    } flush_t;

    localparam stall_t STALL_ALL = stall_t'(4'hf);
    localparam flush_t FLUSH_ALL = flush_t'(4'hf);

    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages (master) and pipe_ctrl (slave).
// PIPE_CTRL_IRQ_EN adds the external-interrupt request signals.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                wb_trap_i;
    logic [PC_WIDTH-1:0] wb_trap_pc_i;
    logic                ex_redirect_i;
    logic [PC_WIDTH-1:0] ex_redirect_pc_i;
    logic                id_load_use_i;
    logic                mem_busy_i;
    logic                if_busy_i;

    logic                if_stall_o;
    logic                id_stall_o;
    logic                ex_stall_o;
    logic                mem_stall_o;
    logic                id_flush_o;
    logic                ex_flush_o;
    logic                mem_flush_o;
    logic                wb_flush_o;
    logic                pc_redirect_o;
    logic [PC_WIDTH-1:0] pc_redirect_pc_o;
    logic                drain_timeout_o;
`ifdef PIPE_CTRL_IRQ_EN
    logic                irq_ext_i;
    logic                mstatus_mie_i;
    logic                mie_meie_i;
    logic                int_req_o;
`endif

    modport master (
`ifdef PIPE_CTRL_IRQ_EN
        output irq_ext_i, mstatus_mie_i, mie_meie_i,
        input  int_req_o,
`endif
        output wb_trap_i, wb_trap_pc_i, ex_redirect_i, ex_redirect_pc_i,
               id_load_use_i, mem_busy_i, if_busy_i,
        input  if_stall_o, id_stall_o, ex_stall_o, mem_stall_o,
               id_flush_o, ex_flush_o, mem_flush_o, wb_flush_o,
               pc_redirect_o, pc_redirect_pc_o, drain_timeout_o
    );

    modport slave (
`ifdef PIPE_CTRL_IRQ_EN
        input  irq_ext_i, mstatus_mie_i, mie_meie_i,
        output int_req_o,
`endif
        input  wb_trap_i, wb_trap_pc_i, ex_redirect_i, ex_redirect_pc_i,
               id_load_use_i, mem_busy_i, if_busy_i,
        output if_stall_o, id_stall_o, ex_stall_o, mem_stall_o,
               id_flush_o, ex_flush_o, mem_flush_o, wb_flush_o,
               pc_redirect_o, pc_redirect_pc_o, drain_timeout_o
    );

endinterface

// File: rtl/pipe_ctrl_drain_cnt.sv
// Saturating drain counter with clear and enable; tc_o flags the last allowed
// drain cycle (count == MAX-1).
module pipe_ctrl_drain_cnt import pipe_ctrl_pkg::*; #(
    parameter int unsigned MAX = 255,
    parameter int unsigned W   = cnt_width(MAX)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX);
    localparam logic [W-1:0] CNT_TC  = W'(MAX - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i)
            cnt_q <= '0;
        else if (en_i && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + W'(1);
    end

    assign tc_o = (cnt_q == CNT_TC);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates trap/branch redirects, load-use and MEM busy,
// and sequences trap entry (flush, drain, redirect). Option: PIPE_CTRL_IRQ_EN.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 64'h8000_0000,
    parameter int unsigned         DRAIN_MAX = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pipe_ctrl_if.slave bus
);

    pctrl_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] tgt_q, redir_pc;
    logic                tgt_ld, redir, timeout, drain_tc, busy;
    stall_t              stall;
    flush_t              flush;

    assign busy = bus.if_busy_i | bus.mem_busy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PCTRL_BOOT;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (tgt_ld)
                tgt_q <= bus.wb_trap_pc_i;
        end
    end

    pipe_ctrl_drain_cnt #(.MAX(DRAIN_MAX)) u_drain_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q == PCTRL_FLUSH),
        .en_i  (state_q == PCTRL_DRAIN),
        .tc_o  (drain_tc)
    );

    always_comb begin
        state_d  = state_q;
        stall    = '0;
        flush    = '0;
        redir    = 1'b0;
        redir_pc = tgt_q;
        timeout  = 1'b0;
        tgt_ld   = 1'b0;
        unique case (state_q)
            PCTRL_BOOT: begin
                redir    = 1'b1;
                redir_pc = RESET_PC;
                flush    = FLUSH_ALL;
                state_d  = PCTRL_RUN;
            end
            PCTRL_RUN: begin
                if (bus.wb_trap_i) begin
                    flush   = FLUSH_ALL;
                    tgt_ld  = 1'b1;
                    state_d = PCTRL_FLUSH;
                end else if (bus.mem_busy_i) begin
                    // EX is held, so a pending branch re-asserts once MEM frees.
                    stall      = STALL_ALL;
                    flush.wb_f = 1'b1;
                end else if (bus.ex_redirect_i) begin
                    redir      = 1'b1;
                    redir_pc   = bus.ex_redirect_pc_i;
                    flush.id_f = 1'b1;
                    flush.ex_f = 1'b1;
                end else if (bus.id_load_use_i) begin
                    stall.if_s = 1'b1;
                    stall.id_s = 1'b1;
                    flush.ex_f = 1'b1;
                end
            end
            PCTRL_FLUSH: begin
                stall   = STALL_ALL;
                flush   = FLUSH_ALL;
                state_d = busy ? PCTRL_DRAIN : PCTRL_REDIR;
            end
            PCTRL_DRAIN: begin
                stall = STALL_ALL;
                flush = FLUSH_ALL;
                if (!busy) begin
                    state_d = PCTRL_REDIR;
                end else if (drain_tc) begin
                    timeout = 1'b1;
                    state_d = PCTRL_REDIR;
                end
            end
            PCTRL_REDIR: begin
                redir      = 1'b1;
                flush.id_f = 1'b1;
                state_d    = PCTRL_RUN;
            end
            default: state_d = PCTRL_BOOT;
        endcase
    end

    // Outputs are forced quiet for as long as reset is held.
    assign bus.if_stall_o       = ~rst_i & stall.if_s;
    assign bus.id_stall_o       = ~rst_i & stall.id_s;
    assign bus.ex_stall_o       = ~rst_i & stall.ex_s;
    assign bus.mem_stall_o      = ~rst_i & stall.mem_s;
    assign bus.id_flush_o       = ~rst_i & flush.id_f;
    assign bus.ex_flush_o       = ~rst_i & flush.ex_f;
    assign bus.mem_flush_o      = ~rst_i & flush.mem_f;
    assign bus.wb_flush_o       = ~rst_i & flush.wb_f;
    assign bus.pc_redirect_o    = ~rst_i & redir;
    assign bus.pc_redirect_pc_o = (~rst_i & redir) ? redir_pc : '0;
    assign bus.drain_timeout_o  = ~rst_i & timeout;

`ifdef PIPE_CTRL_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            irq_q <= 1'b0;
        else
            irq_q <= bus.irq_ext_i & bus.mstatus_mie_i & bus.mie_meie_i
                   & (state_q inside {PCTRL_BOOT, PCTRL_RUN});
    end

    assign bus.int_req_o = ~rst_i & irq_q & (state_q == PCTRL_RUN) & ~bus.wb_trap_i;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic checked
// cycle by cycle against a cycle-count reference model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [PC_WIDTH-1:0] RESET_PC  = 64'h8000_0000;
    localparam int                  DRAIN_MAX = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if bus();

    pipe_ctrl #(.RESET_PC(RESET_PC), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_fail  = 0;
    int to_seen = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: pending boot/redirect flags, a trap-in-progress flag
    // and a count of cycles spent waiting for the buses.
    bit          m_boot, m_trap, m_drain, m_redir;
    int          m_dn;
    logic [63:0] m_pc;
    logic        m_irq = 1'b0;

    task automatic model(output logic [9:0] ev, output logic [63:0] epc, output logic eirq);
        logic [3:0] st, fl;
        logic       rd, to, busy, irq_and;
        bit         normal, mask;
        st = 4'h0; fl = 4'h0; rd = 1'b0; to = 1'b0; epc = 64'h0;
        normal  = 1'b0;
        mask    = m_trap | m_redir;
        busy    = bus.if_busy_i | bus.mem_busy_i;
        irq_and = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
        irq_and = bus.irq_ext_i & bus.mstatus_mie_i & bus.mie_meie_i;
`endif
        if (rst) begin
            m_boot = 1; m_trap = 0; m_drain = 0; m_redir = 0;
        end else if (m_boot) begin
            rd = 1'b1; epc = RESET_PC; fl = 4'hf; m_boot = 0;
        end else if (m_redir) begin
            rd = 1'b1; epc = m_pc; fl = 4'b1000; m_redir = 0;
        end else if (m_trap) begin
            st = 4'hf; fl = 4'hf;
            if (!m_drain) begin
                if (busy) begin m_drain = 1; m_dn = 0; end
                else begin m_redir = 1; m_trap = 0; end
            end else begin
                m_dn++;
                if (!busy || m_dn == DRAIN_MAX) begin
                    to = busy; m_redir = 1; m_trap = 0; m_drain = 0;
                end
            end
        end else begin
            normal = 1'b1;
            if (bus.wb_trap_i) begin
                fl = 4'hf; m_trap = 1; m_drain = 0; m_pc = bus.wb_trap_pc_i;
            end else if (bus.mem_busy_i) begin
                st = 4'hf; fl = 4'b0001;
            end else if (bus.ex_redirect_i) begin
                rd = 1'b1; epc = bus.ex_redirect_pc_i; fl = 4'b1100;
            end else if (bus.id_load_use_i) begin
                st = 4'b1100; fl = 4'b0100;
            end
        end
        eirq  = normal & m_irq & ~bus.wb_trap_i;
        m_irq = ~rst & ~mask & irq_and;
        ev    = {st, fl, rd, to};
    endtask

    task automatic tick(input string tag);
        logic [9:0]  ev, got;
        logic [63:0] epc;
        logic        eirq;
        @(negedge clk);
        model(ev, epc, eirq);
        got = {bus.if_stall_o, bus.id_stall_o, bus.ex_stall_o, bus.mem_stall_o,
               bus.id_flush_o, bus.ex_flush_o, bus.mem_flush_o, bus.wb_flush_o,
               bus.pc_redirect_o, bus.drain_timeout_o};
        if (bus.drain_timeout_o) to_seen++;
        chk(tag, 64'(got), 64'(ev));
        if (ev[1]) chk({tag, ".pc"}, bus.pc_redirect_pc_o, epc);
`ifdef PIPE_CTRL_IRQ_EN
        chk({tag, ".irq"}, 64'(bus.int_req_o), 64'(eirq));
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_trap_i        = 1'b0;
        bus.wb_trap_pc_i     = '0;
        bus.ex_redirect_i    = 1'b0;
        bus.ex_redirect_pc_i = '0;
        bus.id_load_use_i    = 1'b0;
        bus.mem_busy_i       = 1'b0;
        bus.if_busy_i        = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
        bus.irq_ext_i     = 1'b0;
        bus.mstatus_mie_i = 1'b0;
        bus.mie_meie_i    = 1'b0;
`endif
    endtask

    initial begin
        logic mb, ib;
        idle();
        rst = 1'b1;
        repeat (3) tick("reset");
        rst = 1'b0;
        tick("boot");
        repeat (8) tick("run_idle");

        // Load-use alone, then load-use overridden by an EX redirect.
        bus.id_load_use_i = 1'b1;        tick("load_use");
        bus.id_load_use_i = 1'b0;        tick("after_lu");
        bus.id_load_use_i = 1'b1;
        bus.ex_redirect_i = 1'b1;
        bus.ex_redirect_pc_i = 64'h100;  tick("lu_exr");
        idle();                          tick("idle");

        // MEM busy holds back a pending EX redirect.
        bus.mem_busy_i = 1'b1;
        bus.ex_redirect_i = 1'b1;
        bus.ex_redirect_pc_i = 64'h200;
        repeat (3) tick("busy_exr");
        bus.mem_busy_i = 1'b0;           tick("exr_released");
        idle();                          tick("idle");

        // Trap without busy; EX redirect during FLUSH must be ignored.
        bus.wb_trap_i = 1'b1;
        bus.wb_trap_pc_i = 64'h2000;     tick("trap");
        idle();
        bus.ex_redirect_i = 1'b1;
        bus.ex_redirect_pc_i = 64'h300;  tick("flush_exr");
        idle();                          tick("trap_redir");
        tick("idle");

        // Trap with MEM busy beyond the drain limit.
        to_seen = 0;
        bus.wb_trap_i = 1'b1;
        bus.wb_trap_pc_i = 64'h4000;
        bus.mem_busy_i = 1'b1;           tick("trap_busy");
        bus.wb_trap_i = 1'b0;
        repeat (300) tick("drain_timeout");
        chk("timeout_pulses", 64'(to_seen), 64'd1);
        bus.mem_busy_i = 1'b0;
        repeat (3) tick("busy_dropped");

        // Busy drops exactly on the terminal drain cycle: no timeout pulse.
        to_seen = 0;
        bus.wb_trap_i = 1'b1;
        bus.wb_trap_pc_i = 64'h5000;
        bus.mem_busy_i = 1'b1;           tick("trap_edge");
        bus.wb_trap_i = 1'b0;            tick("flush_edge");
        repeat (254) tick("drain_edge");
        bus.mem_busy_i = 1'b0;           tick("drain_both");
        tick("redir_edge");
        chk("edge_no_pulse", 64'(to_seen), 64'd0);

        // Short drain on IF busy, then reset in the middle of a drain.
        bus.wb_trap_i = 1'b1;
        bus.wb_trap_pc_i = 64'h6000;
        bus.if_busy_i = 1'b1;            tick("trap_ifbusy");
        bus.wb_trap_i = 1'b0;
        repeat (6) tick("drain_if");
        bus.if_busy_i = 1'b0;            tick("drain_exit");
        tick("redir_if");
        to_seen = 0;
        bus.wb_trap_i = 1'b1;
        bus.wb_trap_pc_i = 64'h7000;
        bus.mem_busy_i = 1'b1;           tick("trap_mid");
        bus.wb_trap_i = 1'b0;
        repeat (20) tick("drain_mid");
        rst = 1'b1;                      tick("reset_mid");
        rst = 1'b0;
        idle();                          tick("boot_mid");
        repeat (300) tick("after_mid");
        chk("mid_reset_no_pulse", 64'(to_seen), 64'd0);

`ifdef PIPE_CTRL_IRQ_EN
        bus.irq_ext_i = 1'b1; bus.mstatus_mie_i = 1'b1; bus.mie_meie_i = 1'b1;
        repeat (4) tick("irq_hold");
        bus.wb_trap_i = 1'b1; bus.wb_trap_pc_i = 64'h8000;
        tick("irq_trap");
        idle();
        repeat (4) tick("irq_after");
`endif

        // Randomized traffic with bursty busy signals and rare resets.
        mb = 1'b0;
        ib = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) mb = ~mb;
            if ($urandom_range(0, 5) == 0) ib = ~ib;
            rst                  = ($urandom_range(0, 249) == 0);
            bus.wb_trap_i        = ($urandom_range(0, 24) == 0);
            bus.wb_trap_pc_i     = {$urandom, $urandom};
            bus.ex_redirect_i    = ($urandom_range(0, 2) == 0);
            bus.ex_redirect_pc_i = {$urandom, $urandom};
            bus.id_load_use_i    = ($urandom_range(0, 2) == 0);
            bus.mem_busy_i       = mb;
            bus.if_busy_i        = ib;
`ifdef PIPE_CTRL_IRQ_EN
            bus.irq_ext_i     = ($urandom_range(0, 3) != 0);
            bus.mstatus_mie_i = ($urandom_range(0, 7) != 0);
            bus.mie_meie_i    = ($urandom_range(0, 7) != 0);
`endif
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core (IF/ID/EX/MEM/WB). It arbitrates between the WB trap/mret redirect, the EX branch/jump redirect, load-use hazards and MEM busy back-pressure. It produces per-stage stall and flush signals plus a single PC redirect to IF. A small FSM sequences trap entry: flush, drain outstanding bus transactions (bounded by a timeout), then redirect.

Parameters:
RESET_PC, 64'h8000_0000, fetch address issued after reset.
DRAIN_MAX, 255, max cycles spent in DRAIN before forcing redirect.

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
wb_trap_i  in  1  WB trap/mret taken this cycle
wb_trap_pc_i  in  PC_WIDTH  trap handler or mepc target
ex_redirect_i  in  1  EX resolved a taken branch, jump or mispredict
ex_redirect_pc_i  in  PC_WIDTH  EX target
id_load_use_i  in  1  ID consumer depends on a load in EX
mem_busy_i  in  1  LSU transaction outstanding, MEM cannot advance
if_busy_i  in  1  fetch bus transaction outstanding
if_stall_o / id_stall_o / ex_stall_o / mem_stall_o  out  1 each  hold that stage's input register
id_flush_o / ex_flush_o / mem_flush_o / wb_flush_o  out  1 each  load a bubble into that stage's input register at the next edge
pc_redirect_o  out  1  IF loads pc_redirect_pc_o
pc_redirect_pc_o  out  PC_WIDTH  redirect target
drain_timeout_o  out  1  one-cycle pulse: DRAIN exited by timeout
int_req_o  out  1  (PIPE_CTRL_IRQ_EN only) interrupt request to WB

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high. While rst_i is high, every output is 0, state is BOOT, the drain counter is 0 and the target register holds RESET_PC.
- FSM states: BOOT, RUN, FLUSH, DRAIN, REDIR.
- BOOT (first cycle after rst_i falls): pc_redirect_o=1, pc_redirect_pc_o=RESET_PC, all four flushes=1; next state RUN.
- RUN priority, all outputs combinational in the same cycle:
  1. wb_trap_i: all flushes=1; latch wb_trap_pc_i into tgt_q; next state FLUSH. No redirect this cycle.
  2. mem_busy_i: if/id/ex/mem stalls=1, wb_flush_o=1; ex_redirect_i is ignored (EX is held and will re-assert).
  3. ex_redirect_i: pc_redirect_o=1 with ex_redirect_pc_i; id_flush_o=1, ex_flush_o=1; no stalls. This also overrides id_load_use_i.
  4. id_load_use_i: if_stall_o=1, id_stall_o=1, ex_flush_o=1.
  5. Otherwise all outputs 0.
- FLUSH: all stalls=1 and all flushes=1.
  - If if_busy_i or mem_busy_i is high: go to DRAIN and clear the counter.
  - Otherwise go to REDIR.
- DRAIN: all stalls=1 and all flushes=1; the counter increments each cycle.
  - Go to REDIR when both busy inputs are low.
  - Also go to REDIR when counter==DRAIN_MAX-1; drain_timeout_o=1 in that exit cycle only.
  - If both conditions hold in the same cycle, no timeout pulse.
  - Counter width is clog2(DRAIN_MAX+1) and it saturates (no wrap).
- REDIR: pc_redirect_o=1 with tgt_q; id_flush_o=1; next state RUN.
  - Minimum trap-to-redirect latency is 2 cycles (RUN to FLUSH to REDIR).
- Outside RUN, wb_trap_i, ex_redirect_i and id_load_use_i are ignored; the stages are flushed, so they are stale.
- A stage is never stalled and flushed for the same cause, except FLUSH/DRAIN where the flush wins. Stage registers apply the rule: flush beats stall.
- Reset asserted in any state returns to BOOT on the next edge. Any in-progress drain is abandoned without a timeout pulse.

Optional Feature:
Macro PIPE_CTRL_IRQ_EN.
- Defined: adds inputs irq_ext_i, mstatus_mie_i, mie_meie_i and output int_req_o.
  - irq_q is registered from irq_ext_i & mstatus_mie_i & mie_meie_i.
  - int_req_o=irq_q only in RUN with wb_trap_i low. It stays high until WB returns wb_trap_i.
  - The irq sample is masked during FLUSH/DRAIN/REDIR.
- Undefined: those ports are absent and the block has no interrupt path.

Decomposition:
- Shared package / defines header:
  - FSM state encoding PCTRL_BOOT..PCTRL_REDIR, 3 bits.
  - PC_WIDTH and XLEN, reused from the existing core defines.
  - The stall/flush bundle bit order.
- One natural sub-module: pipe_ctrl_drain_cnt, a saturating counter with clear, enable and a terminal-count output.

Test Plan:
- Reset release: rst_i 1 to 0 -> one cycle pc_redirect_o=1, pc=8000_0000, all flushes=1; next cycle all outputs 0.
- Load-use at cycle 10 -> if/id stall=1, ex_flush=1 for exactly that cycle. Simultaneous ex_redirect_i=1, pc=0x100 -> redirect to 0x100, id/ex flush, no stalls.
- mem_busy_i=1 with ex_redirect_i=1 for 3 cycles, then busy=0 -> no redirect during busy; redirect in the 4th cycle; wb_flush_o=1 during busy.
- wb_trap_i, pc=0x2000, with no busy -> cycle+1 FLUSH, cycle+2 pc_redirect_o=1 to 0x2000; ex_redirect_i asserted during FLUSH is ignored.
- Trap with mem_busy_i held high for 300 cycles (DRAIN_MAX=255) -> drain_timeout_o pulses once; redirect the next cycle; busy later dropping causes no further action.
- PIPE_CTRL_IRQ_EN defined: irq, mie and meie all 1 -> int_req_o high 1 cycle later and held until wb_trap_i. Mid-drain reset -> BOOT, no timeout pulse.
